// File: rtl/homomorphic_seq.sv
// homomorphic_seq: frame sequencer in front of the homomorphic envelogram datapath
// (abs -> log -> Butterworth LP -> exp).
//
// Accepts a frame of n_samples PCG samples over in_valid/in_ready and issues them
// one at a time on dp_data. A credit counter (outstanding) tracks samples inside
// the datapath. Results strobed by dp_we are captured into a show-ahead output FIFO.
// The block pulses done when the frame has drained, or flags err_timeout if results
// stop arriving.
//
// Optional build macro: HOMOMORPHIC_SEQ_DECIM_EN
//   When defined, only every DECIM-th valid result is kept. Discarded results still
//   return their credit. When undefined, every valid result is kept.
//
// Ports:
//   CLK, RST          clock and asynchronous active-high reset
//   start, n_samples  frame start pulse and frame length (latched on start)
//   in_valid/in_ready/in_data    sample input handshake
//   dp_data           sample driven to the datapath (registered)
//   dp_result, dp_we  datapath result and its strobe
//   out_valid/out_ready/out_data FIFO head (show-ahead)
//   busy, done        RUN/DRAIN indicator, one-cycle end-of-frame pulse
//   err_timeout, err_spurious    sticky errors, cleared on start
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | issuing samples until issued = n_latched
// DRAIN | all issued, waiting for outstanding results (timeout armed)
// DONE  | one cycle, done = 1

module homomorphic_seq #(
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT         = 1024,
  parameter int DECIM           = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] n_samples,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] dp_data,
  input  logic [15:0] dp_result,
  input  logic        dp_we,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_spurious
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > FIFO_DEPTH ||
      TIMEOUT < 1 || DECIM < 1) begin : g_bad_param
    $error("homomorphic_seq: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic [15:0]   n_latched;
  logic [15:0]   issued;
  logic [OW-1:0] outstanding;
  logic          armed;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [TW-1:0] tmo_left;

  logic start_go;
  logic accept;
  logic res_ok;
  logic res_bad;
  logic keep;
  logic do_push;
  logic pop;
  logic tmo_run;
  logic tmo_fire;

  // Credit check: a sample is only issued if its result is guaranteed a FIFO slot.
  assign in_ready = (state == S_RUN) && (issued < n_latched) &&
                    (outstanding < OW'(MAX_OUTSTANDING)) &&
                    ((int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH);

  assign start_go = (state == S_IDLE) && start;
  assign accept   = in_valid && in_ready;
  assign res_ok   = dp_we && (outstanding != '0);
  assign res_bad  = dp_we && (outstanding == '0);

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 16'h0000;
  assign pop       = out_valid && out_ready;
  // A push into a full FIFO can only land when the head leaves the same cycle.
  assign do_push   = keep && ((fifo_count != CW'(FIFO_DEPTH)) || pop);

`ifdef HOMOMORPHIC_SEQ_DECIM_EN
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [PW-1:0] phase;

  assign keep = res_ok && (phase == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= '0;
    end else if (start_go) begin
      phase <= '0;
    end else if (res_ok) begin
      phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
    end
  end
`else
  assign keep = res_ok;
`endif

  // Timeout down-counter: reloaded whenever a result arrives or nothing is pending.
  assign tmo_run  = ((state == S_RUN) || (state == S_DRAIN)) &&
                    (outstanding != '0) && !dp_we;
  assign tmo_fire = tmo_run && (state == S_DRAIN) && (tmo_left <= TW'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_left <= TW'(TIMEOUT);
    end else if (!tmo_run) begin
      tmo_left <= TW'(TIMEOUT);
    end else if (tmo_left != '0) begin
      tmo_left <= tmo_left - TW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      n_latched    <= '0;
      issued       <= '0;
      outstanding  <= '0;
      armed        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) issued <= issued + 16'd1;
      case ({accept, res_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
      // Results still in flight from before a reset are not reported until a
      // frame has been started again.
      if (res_bad && armed) err_spurious <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            n_latched    <= n_samples;
            issued       <= '0;
            outstanding  <= '0;
            armed        <= 1'b1;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            if (n_samples == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issued == n_latched) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (outstanding == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmo_fire) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dp_data <= '0;
    end else if (accept) begin
      dp_data <= in_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) fifo_mem[wr_ptr] <= dp_result;
  end

endmodule
